// File: rtl/rv32_pkg.sv
// Shared types for the RV32 instruction-memory loader: FSM states and error codes.
package rv32_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CKSUM,
      DONE,
      ERR
   } loader_state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_LEN   = 2'b01;
   localparam logic [1:0] ERR_CKSUM = 2'b10;

endpackage

// File: rtl/loader_word_pack.sv
// Assembles four stream bytes into one little-endian 32-bit word.
module loader_word_pack
   import rv32_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic        word_ready_o,
   output logic [31:0] word_o
);

   logic [1:0]  idx_q, idx_d;
   logic [23:0] part_q, part_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q  <= '0;
         part_q <= '0;
      end else begin
         idx_q  <= idx_d;
         part_q <= part_d;
      end
   end

   always_comb begin
      idx_d  = idx_q;
      part_d = part_q;
      if (clear_i) begin
         idx_d  = '0;
         part_d = '0;
      end else if (byte_en_i) begin
         idx_d = idx_q + 2'd1;
         case (idx_q)
            2'd0:    part_d[7:0]   = byte_i;
            2'd1:    part_d[15:8]  = byte_i;
            2'd2:    part_d[23:16] = byte_i;
            default: ;
         endcase
      end
   end

   // The fourth byte is never stored; it completes the word combinationally.
   assign word_ready_o = byte_en_i && (idx_q == 2'd3);
   assign word_o       = {byte_i, part_q};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed image into instruction memory and
// holds the core stalled until a verified image is in place.
module imem_loader
   import rv32_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   output logic              byte_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              stop_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_code_o,
   output logic [ADDR_W:0]   words_o
);

   localparam logic [15:0]     MaxWords = 16'(MAX_WORDS);
   localparam logic [ADDR_W:0] WordOne  = {{ADDR_W{1'b0}}, 1'b1};

   loader_state_t     state_q, state_d;
   logic [7:0]        lenLo_q, lenLo_d;
   logic [ADDR_W:0]   nWords_q, nWords_d;
   logic [ADDR_W:0]   wordCount_q, wordCount_d;
   logic [7:0]        cksum_q, cksum_d;
   logic [1:0]        errCode_q, errCode_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic        xfer;
   logic        packClear;
   logic        packEn;
   logic        wordReady;
   logic [31:0] word;
   logic [15:0] lenFull;

   assign byte_ready_o = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                         (state_q == DATA)   || (state_q == CKSUM);
   assign xfer         = byte_valid_i && byte_ready_o;
   assign packEn       = xfer && (state_q == DATA);

   loader_word_pack u_pack (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (packClear),
      .byte_en_i    (packEn),
      .byte_i       (byte_data_i),
      .word_ready_o (wordReady),
      .word_o       (word)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         lenLo_q     <= '0;
         nWords_q    <= '0;
         wordCount_q <= '0;
         cksum_q     <= '0;
         errCode_q   <= ERR_NONE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         lenLo_q     <= lenLo_d;
         nWords_q    <= nWords_d;
         wordCount_q <= wordCount_d;
         cksum_q     <= cksum_d;
         errCode_q   <= errCode_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lenLo_d     = lenLo_q;
      nWords_d    = nWords_q;
      wordCount_d = wordCount_q;
      cksum_d     = cksum_q;
      errCode_d   = errCode_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      packClear   = 1'b0;
      lenFull     = {byte_data_i, lenLo_q};

      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start_i) begin
               state_d     = LEN_LO;
               wordCount_d = '0;
               cksum_d     = '0;
               errCode_d   = ERR_NONE;
               packClear   = 1'b1;
            end
         end
         LEN_LO: begin
            if (xfer) begin
               lenLo_d = byte_data_i;
               cksum_d = cksum_q ^ byte_data_i;
               state_d = LEN_HI;
            end
         end
         LEN_HI: begin
            if (xfer) begin
               cksum_d  = cksum_q ^ byte_data_i;
               nWords_d = lenFull[ADDR_W:0];
               if (lenFull > MaxWords) begin
                  state_d   = ERR;
                  errCode_d = ERR_LEN;
               end else if (lenFull == 16'd0) begin
                  state_d = CKSUM;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (xfer) begin
               cksum_d = cksum_q ^ byte_data_i;
               if (wordReady) begin
                  we_d        = 1'b1;
                  addr_d      = wordCount_q[ADDR_W-1:0];
                  wdata_d     = word;
                  wordCount_d = wordCount_q + WordOne;
                  if (wordCount_q + WordOne == nWords_q) begin
                     state_d = CKSUM;
                  end
               end
            end
         end
         CKSUM: begin
            if (xfer) begin
               if (byte_data_i == cksum_q) begin
                  state_d = DONE;
               end else begin
                  state_d   = ERR;
                  errCode_d = ERR_CKSUM;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign stop_o       = (state_q != DONE);
   assign done_o       = (state_q == DONE);
   assign err_o        = (state_q == ERR);
   assign err_code_o   = errCode_q;
   assign words_o      = wordCount_q;

endmodule
